// File: rtl/cpu8080_pkg.sv
// cpu8080_pkg: shared types and constants for the 8080 internal data-bus arbitration.
package cpu8080_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, HOLD} arb_state_t;
  localparam int NUM_BUS_SOURCES = 9;
  localparam logic [3:0] OWNER_NONE = 4'hF;
  localparam logic [3:0] SRC_ALU     = 4'd0;
  localparam logic [3:0] SRC_ACC     = 4'd1;
  localparam logic [3:0] SRC_TMP     = 4'd2;
  localparam logic [3:0] SRC_REG_HI  = 4'd3;
  localparam logic [3:0] SRC_REG_LO  = 4'd4;
  localparam logic [3:0] SRC_FLAGS   = 4'd5;
  localparam logic [3:0] SRC_DATA_IN = 4'd6;
  localparam logic [3:0] SRC_ADDR_HI = 4'd7;
  localparam logic [3:0] SRC_ADDR_LO = 4'd8;
  function automatic logic [3:0] next_ptr(input logic [3:0] idx, input int n);
    return (int'(idx) == n - 1) ? 4'd0 : idx + 4'd1;
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick of the first set request at or after ptr.
module rr_priority_picker #(
  parameter int N = 9,
  parameter int IW = 4
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  exclude,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          any_valid
);
  logic [N-1:0] m;
  logic found;
  assign m = req & ~exclude;
  assign any_valid = |m;
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && m[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        win[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/bus_source_arbiter.sv
// bus_source_arbiter: round-robin owner of the internal data-bus mux with bounded locked holds.
module bus_source_arbiter
  import cpu8080_pkg::*;
#(
  parameter int NUM_SOURCES = NUM_BUS_SOURCES,
  parameter int HOLD_MAX = 4,
  parameter int CNT_W = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] req,
  input  logic                   lock,
  output logic [NUM_SOURCES-1:0] grant,
  output logic [3:0]             owner,
  output logic                   bus_busy,
  output logic                   hold_timeout
);
  arb_state_t state, state_n;
  logic [NUM_SOURCES-1:0] grant_n, win, excl;
  logic [3:0] owner_n, win_idx, rr_ptr, ptr_n;
  logic [CNT_W-1:0] hold_cnt, cnt_n;
  logic any, locked, at_max, hold_go, timeout_n;
  assign locked = lock && |(req & grant);
  assign at_max = hold_cnt >= CNT_W'(HOLD_MAX);
  // a hold that ran out must hand the bus to someone else this cycle
  assign excl = (state == HOLD && locked && at_max) ? grant : '0;
  assign hold_go = locked && ((state == GRANT && HOLD_MAX != 0) || (state == HOLD && !at_max));
  rr_priority_picker #(.N(NUM_SOURCES), .IW(4)) u_pick (
    .req(req),
    .ptr(rr_ptr),
    .exclude(excl),
    .win(win),
    .idx(win_idx),
    .any_valid(any)
  );
  always_comb begin
    state_n = state;
    grant_n = grant;
    owner_n = owner;
    ptr_n = rr_ptr;
    cnt_n = hold_cnt;
    timeout_n = 1'b0;
    if (hold_go) begin
      state_n = HOLD;
      cnt_n = (state == GRANT) ? CNT_W'(1) : hold_cnt + 1'b1;
    end else begin
      state_n = any ? GRANT : IDLE;
      grant_n = win;
      owner_n = any ? win_idx : OWNER_NONE;
      ptr_n = any ? next_ptr(win_idx, NUM_SOURCES) : rr_ptr;
      cnt_n = '0;
      timeout_n = |excl;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      owner <= OWNER_NONE;
      bus_busy <= 1'b0;
      hold_timeout <= 1'b0;
      rr_ptr <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      owner <= owner_n;
      bus_busy <= |grant_n;
      hold_timeout <= timeout_n;
      rr_ptr <= ptr_n;
      hold_cnt <= cnt_n;
    end
  end
endmodule
